// File: rtl/mem32_arbiter_if.sv
// Requester command/response channels plus the mem32 pin bundle.
// master = arbiter view; slave = requesters and memory view.
interface mem32_arbiter_if;
   logic        req0_valid, req0_ready, req0_wr;
   logic [3:0]  req0_add;
   logic [31:0] req0_wdata;
   logic        req1_valid, req1_ready, req1_wr;
   logic [3:0]  req1_add;
   logic [31:0] req1_wdata;
   logic        rsp0_valid, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        rsp1_valid, rsp1_err;
   logic [31:0] rsp1_rdata;
   logic        mem_wr, mem_rd, mem_valid;
   logic [3:0]  mem_add;
   logic [31:0] mem_wdata, mem_rdata;

   modport master (
      input  req0_valid, req0_wr, req0_add, req0_wdata,
      input  req1_valid, req1_wr, req1_add, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_err, rsp0_rdata,
      output rsp1_valid, rsp1_err, rsp1_rdata,
      output mem_wr, mem_rd, mem_add, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      output req0_valid, req0_wr, req0_add, req0_wdata,
      output req1_valid, req1_wr, req1_add, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_err, rsp0_rdata,
      input  rsp1_valid, rsp1_err, rsp1_rdata,
      input  mem_wr, mem_rd, mem_add, mem_wdata,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/mem32_arbiter.sv
// Round-robin two-port sequencer for mem32; write 3 cycles, read >=3 cycles or TIMEOUT+2 on error.
// Ready only in IDLE for the winner; responses are unbackpressured single-cycle pulses.
module mem32_arbiter #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic            Clk,
   input  logic            rst,
   mem32_arbiter_if.master bus,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        owner_q, last_q;
   logic [3:0]  add_q;
   logic [31:0] wdata_q, rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q;
   logic        winner, take, win_wr;

   // On a tie the port not granted last wins; otherwise the lone requester.
   assign winner = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
   assign take   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
   assign win_wr = winner ? bus.req1_wr : bus.req0_wr;
   assign bus.req0_ready = take && !winner;
   assign bus.req1_ready = take && winner;
   assign busy = (state_q != IDLE);

   always_comb begin
      state_d        = state_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      bus.mem_wr     = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_add    = 4'd0;
      bus.mem_wdata  = 32'd0;
      bus.rsp0_valid = 1'b0;
      bus.rsp0_rdata = 32'd0;
      bus.rsp0_err   = 1'b0;
      bus.rsp1_valid = 1'b0;
      bus.rsp1_rdata = 32'd0;
      bus.rsp1_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (take) state_d = win_wr ? WRITE : READ;
         end
         WRITE: begin
            bus.mem_wr    = 1'b1;
            bus.mem_add   = add_q;
            bus.mem_wdata = wdata_q;
            rdata_d       = 32'd0;
            err_d         = 1'b0;
            state_d       = RESP;
         end
         READ: begin
            bus.mem_rd  = 1'b1;
            bus.mem_add = add_q;
            // A valid on the final counted cycle still wins over the timeout.
            if (bus.mem_valid) begin
               rdata_d = bus.mem_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (owner_q) begin
               bus.rsp1_valid = 1'b1;
               bus.rsp1_rdata = rdata_q;
               bus.rsp1_err   = err_q;
            end else begin
               bus.rsp0_valid = 1'b1;
               bus.rsp0_rdata = rdata_q;
               bus.rsp0_err   = err_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         add_q   <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (take) begin
            owner_q <= winner;
            last_q  <= winner;
            add_q   <= winner ? bus.req1_add : bus.req0_add;
            wdata_q <= winner ? bus.req1_wdata : bus.req0_wdata;
            cnt_q   <= 8'd0;
         end else if (state_q == READ) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mem32_arbiter.sv
// Directed bench for mem32_arbiter with a behavioural mem32 model whose valid timing is selectable.
module tb_mem32_arbiter;
   logic Clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   int   total = 0;
   int   bad = 0;
   int   mode = 0;    // 0: valid on 2nd rd cycle, 1: never, 2: valid on 8th rd cycle
   int   rd_cnt = 0;
   logic [31:0] mem [16];

   mem32_arbiter_if bus();
   mem32_arbiter #(.TIMEOUT(8)) dut (.Clk(Clk), .rst(rst), .bus(bus), .busy(busy));

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (bus.mem_wr) mem[bus.mem_add] <= bus.mem_wdata;
      rd_cnt <= bus.mem_rd ? rd_cnt + 1 : 0;
   end

   always_comb begin
      bus.mem_rdata = mem[bus.mem_add];
      bus.mem_valid = bus.mem_rd && ((mode == 0 && rd_cnt == 1) || (mode == 2 && rd_cnt == 7));
   end

   task automatic issue(input bit port, input bit wr, input logic [3:0] add,
                        input logic [31:0] data, output bit ok);
      bit seen;
      ok = 1'b0;
      if (port == 1'b0) begin
         bus.req0_wr = wr; bus.req0_add = add; bus.req0_wdata = data; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_wr = wr; bus.req1_add = add; bus.req1_wdata = data; bus.req1_valid = 1'b1;
      end
      for (int n = 0; n < 20 && !ok; n++) begin
         #1;
         seen = (port == 1'b0) ? bus.req0_ready : bus.req1_ready;
         @(posedge Clk); #1;
         if (seen) ok = 1'b1;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(input bit port, input int max, output int cycles,
                           output logic [31:0] rdata, output logic err);
      cycles = 0; rdata = 'x; err = 'x;
      for (int n = 1; n <= max && cycles == 0; n++) begin
         @(posedge Clk); #1;
         if (port == 1'b0 && bus.rsp0_valid) begin cycles = n; rdata = bus.rsp0_rdata; err = bus.rsp0_err; end
         if (port == 1'b1 && bus.rsp1_valid) begin cycles = n; rdata = bus.rsp1_rdata; err = bus.rsp1_err; end
      end
   endtask

   task automatic test_reset;
      logic [6:0] flags;
      #3;
      flags = {busy, bus.mem_wr, bus.mem_rd, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready};
      total++;
      if (flags !== 7'd0) begin bad++; $display("FAIL reset_flags: got %b want 0000000", flags); end
      total++;
      if ({bus.mem_add, bus.mem_wdata, bus.rsp0_rdata, bus.rsp1_rdata} !== 100'd0) begin
         bad++; $display("FAIL reset_buses: add=%h wdata=%h", bus.mem_add, bus.mem_wdata);
      end
      repeat (2) @(posedge Clk);
      #1 rst = 1'b1;
      #1;
   endtask

   task automatic test_write;
      bit ok;
      bus.req0_wr = 1'b1; bus.req0_add = 4'd0; bus.req0_wdata = 32'hDEADBEEF; bus.req0_valid = 1'b1;
      #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         bad++; $display("FAIL write_ready: got %b want 10", {bus.req0_ready, bus.req1_ready});
      end
      issue(1'b0, 1'b1, 4'd0, 32'hDEADBEEF, ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL write_accept: got %b want 1", ok); end
      total++;
      if ({bus.mem_wr, bus.mem_rd, bus.mem_add, bus.mem_wdata} !== {2'b10, 4'd0, 32'hDEADBEEF}) begin
         bad++; $display("FAIL write_pins: wr=%b rd=%b add=%h wdata=%h want 1 0 0 deadbeef",
                         bus.mem_wr, bus.mem_rd, bus.mem_add, bus.mem_wdata);
      end
      total++;
      if (bus.rsp0_valid !== 1'b0) begin bad++; $display("FAIL write_early_rsp: got %b want 0", bus.rsp0_valid); end
      @(posedge Clk); #1;
      total++;
      if ({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata, bus.mem_wr} !== {2'b10, 32'd0, 1'b0}) begin
         bad++; $display("FAIL write_rsp: valid=%b err=%b rdata=%h mem_wr=%b want 1 0 0 0",
                         bus.rsp0_valid, bus.rsp0_err, bus.rsp0_rdata, bus.mem_wr);
      end
      total++;
      if (bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL write_rsp1_quiet: got %b want 0", bus.rsp1_valid); end
      @(posedge Clk); #1;
      total++;
      if ({busy, bus.rsp0_valid} !== 2'b00) begin
         bad++; $display("FAIL write_done: busy=%b rsp0=%b want 0 0", busy, bus.rsp0_valid);
      end
   endtask

   task automatic test_read_hit;
      bit ok; int cyc; logic [31:0] rd; logic er;
      mode = 0;
      issue(1'b0, 1'b1, 4'd4, 32'hCAFEBABE, ok);  wait_rsp(1'b0, 10, cyc, rd, er);
      issue(1'b0, 1'b1, 4'd12, 32'h12345678, ok); wait_rsp(1'b0, 10, cyc, rd, er);
      issue(1'b0, 1'b0, 4'd12, 32'd0, ok);        wait_rsp(1'b0, 10, cyc, rd, er);
      total++;
      if (rd !== 32'h12345678) begin bad++; $display("FAIL read12_data: got %h want 12345678", rd); end
      issue(1'b1, 1'b0, 4'd4, 32'd0, ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL read_hit_accept: got %b want 1", ok); end
      wait_rsp(1'b1, 10, cyc, rd, er);
      total++;
      if (cyc != 2) begin bad++; $display("FAIL read_hit_latency: got %0d edges want 2", cyc); end
      total++;
      if ({rd, er} !== {32'hCAFEBABE, 1'b0}) begin
         bad++; $display("FAIL read_hit_data: got %h err=%b want cafebabe err=0", rd, er);
      end
   endtask

   task automatic test_arbitration;
      int left0 = 4, left1 = 4, r0 = 0, r1 = 0, gi = 0, overlap = 0, bad_data = 0;
      logic [7:0] got = 8'd0;
      logic [7:0] want = 8'hAA;
      bit g0, g1;
      mode = 0;
      @(posedge Clk); #1;
      bus.req0_wr = 1'b0; bus.req0_add = 4'd0;  bus.req0_valid = 1'b1;
      bus.req1_wr = 1'b0; bus.req1_add = 4'd12; bus.req1_valid = 1'b1;
      for (int n = 0; n < 200 && !(r0 == 4 && r1 == 4); n++) begin
         #1;
         if (bus.rsp0_valid) begin r0++; if (bus.rsp0_rdata !== 32'hDEADBEEF || bus.rsp0_err) bad_data++; end
         if (bus.rsp1_valid) begin r1++; if (bus.rsp1_rdata !== 32'h12345678 || bus.rsp1_err) bad_data++; end
         if (bus.req0_ready && bus.req1_ready) overlap++;
         g0 = bus.req0_valid && bus.req0_ready;
         g1 = bus.req1_valid && bus.req1_ready;
         if (g0 || g1) begin if (gi < 8) got[gi] = g1; gi++; end
         @(posedge Clk); #1;
         if (g0) begin left0--; if (left0 == 0) bus.req0_valid = 1'b0; end
         if (g1) begin left1--; if (left1 == 0) bus.req1_valid = 1'b0; end
      end
      total++;
      if (overlap != 0) begin bad++; $display("FAIL arb_ready_overlap: got %0d want 0", overlap); end
      total++;
      if (gi != 8 || got !== want) begin bad++; $display("FAIL arb_order: got %0d grants %b want 8 %b", gi, got, want); end
      total++;
      if (r0 != 4 || r1 != 4) begin bad++; $display("FAIL arb_rsp_count: got %0d/%0d want 4/4", r0, r1); end
      total++;
      if (bad_data != 0) begin bad++; $display("FAIL arb_rsp_data: got %0d bad responses want 0", bad_data); end
   endtask

   task automatic test_timeout;
      bit ok, done = 1'b0; int rdcyc = 0; logic [31:0] rd = 'x; logic er = 'x;
      mode = 1;
      @(posedge Clk); #1;
      issue(1'b0, 1'b0, 4'd14, 32'd0, ok);
      for (int n = 0; n < 40 && !done; n++) begin
         if (bus.mem_rd) rdcyc++;
         if (bus.rsp0_valid) begin done = 1'b1; rd = bus.rsp0_rdata; er = bus.rsp0_err; end
         @(posedge Clk); #1;
      end
      total++;
      if (rdcyc != 8) begin bad++; $display("FAIL timeout_rd_cycles: got %0d want 8", rdcyc); end
      total++;
      if ({done, er, rd} !== {2'b11, 32'd0}) begin
         bad++; $display("FAIL timeout_rsp: seen=%b err=%b rdata=%h want 1 1 0", done, er, rd);
      end
      total++;
      if ({busy, bus.mem_rd} !== 2'b00) begin bad++; $display("FAIL timeout_idle: busy=%b rd=%b want 0 0", busy, bus.mem_rd); end
   endtask

   task automatic test_reset_mid_read;
      bit ok; int cyc; int spur = 0; logic [31:0] rd; logic er;
      mode = 1;
      issue(1'b1, 1'b0, 4'd5, 32'd0, ok);
      repeat (2) begin @(posedge Clk); #1; end
      total++;
      if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL midrst_reading: got %b want 1", bus.mem_rd); end
      rst = 1'b0;
      #1;
      total++;
      if ({bus.mem_rd, busy} !== 2'b00) begin bad++; $display("FAIL midrst_async: rd=%b busy=%b want 0 0", bus.mem_rd, busy); end
      for (int n = 0; n < 3; n++) begin
         @(posedge Clk); #1;
         if (bus.rsp0_valid || bus.rsp1_valid) spur++;
      end
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge Clk); #1;
         if (bus.rsp0_valid || bus.rsp1_valid) spur++;
      end
      total++;
      if (spur != 0) begin bad++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", spur); end
      mode = 0;
      bus.req0_wr = 1'b0; bus.req0_add = 4'd0;  bus.req0_valid = 1'b1;
      bus.req1_wr = 1'b0; bus.req1_add = 4'd12; bus.req1_valid = 1'b1;
      #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         bad++; $display("FAIL midrst_tie: got %b want 10", {bus.req0_ready, bus.req1_ready});
      end
      @(posedge Clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_rsp(1'b0, 10, cyc, rd, er);
      total++;
      if ({rd, er} !== {32'hDEADBEEF, 1'b0} || cyc != 2) begin
         bad++; $display("FAIL midrst_read: got %h err=%b edges=%0d want deadbeef 0 2", rd, er, cyc);
      end
   endtask

   task automatic test_late_valid;
      bit ok; int cyc; logic [31:0] rd; logic er;
      mode = 2;
      @(posedge Clk); #1;
      issue(1'b1, 1'b0, 4'd12, 32'd0, ok);
      wait_rsp(1'b1, 20, cyc, rd, er);
      total++;
      if (cyc != 8) begin bad++; $display("FAIL late_latency: got %0d edges want 8", cyc); end
      total++;
      if ({rd, er} !== {32'h12345678, 1'b0}) begin
         bad++; $display("FAIL late_data: got %h err=%b want 12345678 0", rd, er);
      end
   endtask

   initial begin
      bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_add = 4'd0; bus.req0_wdata = 32'd0;
      bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_add = 4'd0; bus.req1_wdata = 32'd0;
      test_reset();
      test_write();
      test_read_hit();
      test_arbitration();
      test_timeout();
      test_reset_mid_read();
      test_late_valid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem32_arbiter.md
# mem32_arbiter

Two-port round-robin arbiter and sequencer for the shared mem32 16-word x 32-bit memory. Each requester presents a single read or write command with a valid/ready handshake. The arbiter grants one command at a time and drives mem32's wr/rd/in_add/Data_in_32 pins. It returns a single-cycle response pulse carrying read data, or an error flag when mem32 never asserts valid.

## Interface
- TIMEOUT, default 8: maximum number of cycles spent in READ waiting for mem_valid before an error response (legal range 1..255).
- Clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N has a command pending.
- req0_ready / req1_ready  out  1  command accepted this cycle; transfer occurs when valid && ready.
- req0_wr / req1_wr  in  1  1 = write, 0 = read.
- req0_add / req1_add  in  4  word address.
- req0_wdata / req1_wdata  in  32  write data.
- rsp0_valid / rsp1_valid  out  1  single-cycle response pulse to requester N.
- rsp0_rdata / rsp1_rdata  out  32  read data; 0 for writes and errors.
- rsp0_err / rsp1_err  out  1  read timed out; meaningful only when rspN_valid = 1.
- mem_wr  out  1  to mem32 wr.
- mem_rd  out  1  to mem32 rd.
- mem_add  out  4  to mem32 in_add.
- mem_wdata  out  32  to mem32 Data_in_32.
- mem_rdata  in  32  from mem32 Data_out_32.
- mem_valid  in  1  from mem32 valid.
- busy  out  1  1 in any state other than IDLE.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - Winner: the only requesting port; if both request, the port not granted last.
  - Last-grant pointer resets so that req0 wins the first tie.
  - reqN_ready = (state == IDLE) && (winner == N). This is combinational, and at most one ready is high.
  - On transfer: register owner, wr, add, and wdata; update the pointer; go to WRITE if wr = 1, else READ.
- WRITE (exactly 1 cycle): mem_wr = 1, mem_add = captured address, mem_wdata = captured data. Next state RESP with err = 0 and rdata = 0.
- READ:
  - mem_rd = 1 and mem_add = captured address, held every cycle in this state.
  - Timeout counter clears on entry and increments each READ cycle.
  - If mem_valid is sampled 1: capture mem_rdata, set err = 0, go to RESP.
  - Otherwise, when count == TIMEOUT-1: set rdata = 0, err = 1, go to RESP.
- RESP (exactly 1 cycle): rspN_valid = 1 for the owner only, with the captured rdata and err. Next state IDLE.
- Memory pins outside WRITE/READ: mem_wr = 0, mem_rd = 0, mem_add = 0, mem_wdata = 0.
- mem_valid is ignored outside READ.
- There is no response backpressure; requesters must accept rspN_valid when it pulses.
- A requester may hold valid through its own response; it is re-arbitrated in IDLE like any other request.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, pointer = "last grant was req1".
- Reset assertion mid-operation aborts the transaction immediately: no response is issued, and mem_wr/mem_rd drop asynchronously.
- Write: accept at edge k, mem_wr in cycle k+1, rsp in cycle k+2, next accept possible at edge k+3 (3 cycles per write).
- Read: accept at edge k, mem_rd from cycle k+1.
  - If mem_valid is first seen at the end of READ cycle j, rsp is in cycle j+1.
  - Minimum 3 cycles total.
  - Timeout case: READ lasts exactly TIMEOUT cycles, then the error rsp.
- Simultaneous requests: the grant alternates 0,1,0,1…. A lone requester may be granted back-to-back.
- Response data and err are registered; they are stable only during the rsp pulse.

## Test plan
- Reset then write: req0 writes add=0, wdata=32'hDEADBEEF → mem_wr pulses one cycle with mem_add=0 and mem_wdata=DEADBEEF; rsp0_valid pulses 2 cycles after accept with err=0; req1 sees nothing.
- Read hit: after writes of CAFEBABE at 4 and 12345678 at 12, req1 reads add=4 with a memory model asserting valid 1 cycle after rd → rsp1_rdata=CAFEBABE, err=0, exactly 3 cycles after accept.
- Arbitration: req0 and req1 both hold valid with 4 reads each → grants alternate starting with req0; each port receives 4 responses, and req0_ready and req1_ready are never high together.
- Timeout: TIMEOUT=8, read add=14, memory never asserts valid → mem_rd is high exactly 8 cycles, then rsp err=1 and rdata=0, then IDLE.
- Reset mid-read: assert rst during READ → mem_rd drops immediately, no rsp is issued; after release, req0 wins a tie and a fresh read of add=0 returns DEADBEEF (memory contents preserved by the model).
- Late valid: memory asserts valid on the TIMEOUT-th READ cycle → data is returned with err=0, not a timeout.
